// File: rtl/pc_sequencer.sv
// PC update sequencer for the multicycle CPU: drives the PC source mux select, PC/EPC load
// enables and the exception-vector fetch. Build with PCSEQ_ALIGN_CHECK_EN to trap misaligned targets.
module pc_sequencer #(
  parameter logic [31:0] VEC_BASE = 32'd252,
  parameter int unsigned MEM_LAT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [1:0]  br_cond,
  input  logic        alu_zero,
  input  logic        alu_gt,
  input  logic        exc_req,
  input  logic [1:0]  exc_code,
  input  logic [31:0] target_addr,
  output logic [2:0]  pc_source,
  output logic        pc_write,
  output logic        epc_write,
  output logic        vec_rd,
  output logic [31:0] vec_addr,
  output logic        busy,
  output logic        done,
  output logic        proto_err
);

  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [2:0] OP_SEQ = 3'd0, OP_BRANCH = 3'd1, OP_JUMP = 3'd2,
                         OP_JR  = 3'd3, OP_RFE    = 3'd4;

  typedef enum logic [2:0] {IDLE, EXEC, EXC_SAVE, EXC_VEC, EXC_LOAD} state_t;

  state_t          state, next_state;
  logic [2:0]      op;
  logic [1:0]      cond;
  logic            zero, gt;
  logic [1:0]      code;
  logic            pend;
  logic [1:0]      pend_code;
  logic [CW-1:0]   cnt;
  logic            taken, misalign, illegal, dropped;

  assign illegal = (req_op > OP_RFE);

  always_comb begin
    unique case (cond)
      2'b00:   taken = zero;
      2'b01:   taken = !zero;
      2'b10:   taken = !gt;
      default: taken = gt;
    endcase
  end

`ifdef PCSEQ_ALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    if (state == EXEC && target_addr[1:0] != 2'b00)
      misalign = (op == OP_JUMP) || (op == OP_JR) || (op == OP_RFE) ||
                 ((op == OP_BRANCH) && taken);
  end
`else
  logic unused_target;
  assign unused_target = ^target_addr;
  assign misalign      = 1'b0;
`endif

  // A request is dropped whenever it cannot be accepted this cycle.
  assign dropped = req_valid && ((state != IDLE) || pend || exc_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (pend || exc_req)   next_state = EXC_SAVE;
        else if (req_valid)    next_state = illegal ? EXC_SAVE : EXEC;
      end
      EXEC:     next_state = misalign ? EXC_SAVE : IDLE;
      EXC_SAVE: next_state = EXC_VEC;
      EXC_VEC:  next_state = (cnt == '0) ? EXC_LOAD : EXC_VEC;
      EXC_LOAD: next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op        <= '0;
      cond      <= '0;
      zero      <= 1'b0;
      gt        <= 1'b0;
      code      <= '0;
      pend      <= 1'b0;
      pend_code <= '0;
      cnt       <= '0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= dropped;
      if (state == IDLE) begin
        // Serving the pending slot frees it, so a same-cycle exc_req refills it.
        if (pend) begin
          code      <= pend_code;
          pend      <= exc_req;
          pend_code <= exc_code;
        end else if (exc_req) begin
          code <= exc_code;
        end else if (req_valid) begin
          op   <= req_op;
          cond <= br_cond;
          zero <= alu_zero;
          gt   <= alu_gt;
          if (illegal) code <= 2'b00;
        end
      end else if (exc_req && !pend) begin
        pend      <= 1'b1;
        pend_code <= exc_code;
      end
      if (misalign)                         code <= 2'b11;
      if (state == EXC_SAVE)                cnt  <= CW'(MEM_LAT - 1);
      else if (state == EXC_VEC && cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    pc_source = 3'd0;
    pc_write  = 1'b0;
    epc_write = 1'b0;
    vec_rd    = 1'b0;
    vec_addr  = '0;
    done      = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      EXEC: begin
        done     = !misalign;
        pc_write = !misalign;
        case (op)
          OP_BRANCH: begin
            pc_write = taken && !misalign;
            if (pc_write) pc_source = 3'd1;
          end
          OP_JUMP: if (pc_write) pc_source = 3'd2;
          OP_JR:   if (pc_write) pc_source = 3'd3;
          OP_RFE:  if (pc_write) pc_source = 3'd4;
          default: pc_source = 3'd0;
        endcase
      end
      EXC_SAVE: epc_write = 1'b1;
      EXC_VEC: begin
        vec_rd   = 1'b1;
        vec_addr = VEC_BASE + {30'd0, code};
      end
      EXC_LOAD: begin
        pc_source = 3'd5;
        pc_write  = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multicycle-CPU controller that sequences every PC update: generates the 3-bit select for the six-input PC source mux, plus pc_write and epc_write.
- Runs the exception entry sequence: save EPC, fetch the vector from memory with fixed latency, load PC.
- Sits between the main control FSM (issues one-cycle requests) and the PC/EPC registers.

Parameters:
- VEC_BASE, 32'd252, byte address of exception vector table; vec_addr = VEC_BASE + code.
- MEM_LAT, 2, memory read latency in cycles (>=1) for the vector fetch.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  one-cycle request strobe from control FSM.
- req_op  in  3  000 SEQ (PC+4), 001 BRANCH, 010 JUMP, 011 JR, 100 RFE; 101-111 illegal.
- br_cond  in  2  00 BEQ, 01 BNE, 10 BLEZ, 11 BGTZ.
- alu_zero  in  1  ALU zero flag.
- alu_gt  in  1  ALU operand A signed >0 flag.
- exc_req  in  1  one-cycle exception strobe.
- exc_code  in  2  00 invalid opcode, 01 overflow, 10 divide-by-zero.
- target_addr  in  32  mux output value; used only with the optional feature.
- pc_source  out  3  mux select: 0 PC+4, 1 branch target, 2 jump target, 3 register (JR), 4 EPC, 5 vector.
- pc_write  out  1  PC load enable.
- epc_write  out  1  EPC load enable.
- vec_rd  out  1  memory read request for vector.
- vec_addr  out  32  vector read address.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the sequence completes.
- proto_err  out  1  one-cycle pulse when req_valid is dropped.

Behaviour:
- States: IDLE, EXEC, EXC_SAVE, EXC_VEC, EXC_LOAD. Outputs are decoded from registered state and latched op, code and flags.
- Reset: async to IDLE. All outputs 0. Pending-exception flag and counter cleared. Reset mid-sequence abandons it with no further pc_write or epc_write.
- IDLE priority: pending exception > exc_req > req_valid.
  - On exception: latch code, go EXC_SAVE.
  - On req_valid: latch req_op, br_cond, alu_zero and alu_gt, go EXEC.
  - Illegal req_op: treated as exception code 00, goes to EXC_SAVE.
  - Simultaneous exc_req and req_valid: the request is dropped and proto_err pulses.
- EXEC (1 cycle): pc_source = op mapping (SEQ 0, BRANCH 1, JUMP 2, JR 3, RFE 4). done=1, then IDLE.
  - pc_write=1 for SEQ, JUMP, JR and RFE.
  - BRANCH: pc_write=1 only if the condition holds, else pc_source=0 and pc_write=0.
  - Conditions: BEQ zero=1; BNE zero=0; BLEZ gt=0; BGTZ gt=1.
  - Request latency: accept edge, then pc_write in the next cycle.
- EXC_SAVE (1 cycle): epc_write=1, pc_source=0.
- EXC_VEC (MEM_LAT cycles): vec_rd=1, vec_addr = VEC_BASE + zero-extended code, held stable. The down-counter is loaded with MEM_LAT-1 and the state exits when the count reaches 0.
- EXC_LOAD (1 cycle): pc_source=5, pc_write=1, done=1, then IDLE.
- Exception sequence length: 2 + MEM_LAT cycles after acceptance.
- exc_req while busy: latched into a one-deep pending slot (first code kept, later ones discarded). It is served on the first IDLE cycle.
- req_valid while busy: ignored, proto_err pulses.
- pc_write and epc_write are never high in the same cycle. pc_source is 0 whenever pc_write=0, except in EXC_VEC where it is also 0.

Optional Feature:
PCSEQ_ALIGN_CHECK_EN
- Defined: in EXEC, for JUMP, JR, RFE or a taken BRANCH, if target_addr[1:0] != 0:
  - pc_write is suppressed and done is not pulsed;
  - next state is EXC_SAVE with code 11, giving vec_addr = VEC_BASE + 3.
- Undefined: target_addr is unused and no alignment check is performed.

Test Plan:
- Reset asserted mid-EXC_VEC: all outputs 0 asynchronously; after release, busy=0 and no pc_write.
- req_valid with SEQ: next cycle pc_source=0, pc_write=1, done=1. Then BEQ with alu_zero=0: pc_write=0, done=1.
- BGTZ with alu_gt=1: pc_source=1, pc_write=1. JR: pc_source=3, pc_write=1. RFE: pc_source=4, pc_write=1.
- exc_req with code 01, MEM_LAT=2:
  - cycle+1: epc_write=1;
  - cycles+2 to +3: vec_rd=1, vec_addr=253;
  - cycle+4: pc_source=5, pc_write=1, done=1.
- exc_req code 10 during EXEC: after done, the pending exception starts EXC_SAVE on the next IDLE cycle with vec_addr=254. A second exc_req while pending is discarded.
- req_op=111: exception sequence with vec_addr=252. With the macro defined, JUMP with target_addr=0x0000_0042 gives pc_write=0 and vec_addr=255.
